// File: rtl/spi_adc_sequencer.sv
// Autonomous ADC scan controller driving the SPI master's register port.
// Arms slave-select, issues one command word per channel, waits for each
// transfer and keeps the 16-bit replies in a small local result bank.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start pulse or period tick
// SS_WR    | 2-cycle write of 16'h0001 to addr 5 (slave-select mask)
// GAP_T    | select-low gap, then wait for TRDY
// WAIT_T   | waiting for readyfordata, bounded by TIMEOUT
// CMD_WR   | 2-cycle write of the channel command word to addr 1
// GAP_R    | select-low gap, then wait for RRDY
// WAIT_R   | waiting for dataavailable, bounded by TIMEOUT
// RD       | 2-cycle read of addr 0, reply captured on the final edge
// STORE    | file the reply (or drop the pipeline-priming one), advance
// ABORT    | timeout: flag err, 2-cycle status-clear write to addr 2
// DONE     | one-cycle done pulse, back to IDLE
module spi_adc_sequencer #(
  parameter int          NUM_CH       = 8,
  parameter logic [15:0] CMD_TEMPLATE = 16'h8310,
  parameter int          CH_SHIFT     = 10,
  parameter bit          PIPELINED    = 1'b1,
  parameter int          TIMEOUT      = 2048,
  parameter int          PERIOD       = 40000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              auto_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              overrun,
  input  logic [2:0]        rd_ch,
  output logic [15:0]       rd_data,
  output logic [NUM_CH-1:0] valid_mask,
  output logic              spi_select,
  output logic [2:0]        mem_addr,
  output logic              read_n,
  output logic              write_n,
  output logic [15:0]       data_from_cpu,
  input  logic [15:0]       data_to_cpu,
  input  logic              readyfordata,
  input  logic              dataavailable
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SS_WR  = 4'd1;
  localparam logic [3:0] S_GAP_T  = 4'd2;
  localparam logic [3:0] S_WAIT_T = 4'd3;
  localparam logic [3:0] S_CMD_WR = 4'd4;
  localparam logic [3:0] S_GAP_R  = 4'd5;
  localparam logic [3:0] S_WAIT_R = 4'd6;
  localparam logic [3:0] S_RD     = 4'd7;
  localparam logic [3:0] S_STORE  = 4'd8;
  localparam logic [3:0] S_ABORT  = 4'd9;
  localparam logic [3:0] S_DONE   = 4'd10;

  localparam int          PW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
  localparam logic [11:0] TMO_LAST = 12'(TIMEOUT - 1);
  localparam logic [2:0]  LAST_CH  = 3'(NUM_CH - 1);
  localparam logic [3:0]  SEQ_CAP  = 4'(NUM_CH - 1);

  logic [3:0]    state, nstate;
  logic          ph;
  logic [11:0]   tmo;
  logic [2:0]    ch;
  logic [3:0]    seq;
  logic [15:0]   rx;
  logic [PW-1:0] per_cnt;
  logic [15:0]   result [NUM_CH];

  logic       tick, trig, enter, discard, store_last;
  logic [2:0] cmd_ch;
  logic [15:0] cmd_word;

  assign tick       = auto_en && (per_cnt == PER_LAST);
  assign trig       = start || tick;
  assign enter      = (nstate != state);
  // With a pipelined slave the first reply of a scan belongs to no command.
  assign discard    = PIPELINED && (seq == 4'd0);
  assign store_last = !discard && (ch == LAST_CH);
  // The trailing pipelined transaction repeats the last channel.
  assign cmd_ch     = (seq >= SEQ_CAP) ? LAST_CH : seq[2:0];
  assign cmd_word   = CMD_TEMPLATE | (16'(cmd_ch) << CH_SHIFT);

  // Free-running period timer, held at zero while auto-trigger is off
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      per_cnt <= '0;
    else if (!auto_en || per_cnt == PER_LAST)
      per_cnt <= '0;
    else
      per_cnt <= per_cnt + 1'b1;
  end

  // Next-state decode
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:   if (trig) nstate = S_SS_WR;
      S_SS_WR:  if (ph) nstate = S_GAP_T;
      S_GAP_T:  nstate = S_WAIT_T;
      S_WAIT_T: if (readyfordata) nstate = S_CMD_WR;
                else if (tmo == TMO_LAST) nstate = S_ABORT;
      S_CMD_WR: if (ph) nstate = S_GAP_R;
      S_GAP_R:  nstate = S_WAIT_R;
      S_WAIT_R: if (dataavailable) nstate = S_RD;
                else if (tmo == TMO_LAST) nstate = S_ABORT;
      S_RD:     if (ph) nstate = S_STORE;
      S_STORE:  nstate = store_last ? S_DONE : S_WAIT_T;
      S_ABORT:  if (ph) nstate = S_DONE;
      S_DONE:   nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  // FSM state, bus outputs (registered from next state), scan bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      ph            <= 1'b0;
      tmo           <= '0;
      ch            <= '0;
      seq           <= '0;
      rx            <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      overrun       <= 1'b0;
      valid_mask    <= '0;
      spi_select    <= 1'b0;
      read_n        <= 1'b1;
      write_n       <= 1'b1;
      mem_addr      <= '0;
      data_from_cpu <= '0;
      for (int k = 0; k < NUM_CH; k++) result[k] <= '0;
    end else begin
      state      <= nstate;
      ph         <= enter ? 1'b0 : ~ph;
      tmo        <= enter ? 12'd0 : tmo + 12'd1;
      spi_select <= nstate inside {S_SS_WR, S_CMD_WR, S_RD, S_ABORT};
      write_n    <= !(nstate inside {S_SS_WR, S_CMD_WR, S_ABORT});
      read_n     <= (nstate != S_RD);
      done       <= (nstate == S_DONE);
      busy       <= !(nstate inside {S_IDLE, S_DONE});

      if (!auto_en)
        overrun <= 1'b0;
      else if (trig && state != S_IDLE)
        overrun <= 1'b1;

      if (trig && state == S_IDLE) begin
        err        <= 1'b0;
        valid_mask <= '0;
        ch         <= '0;
        seq        <= '0;
      end

      if (enter) begin
        case (nstate)
          S_SS_WR:  begin mem_addr <= 3'd5; data_from_cpu <= 16'h0001; end
          S_CMD_WR: begin mem_addr <= 3'd1; data_from_cpu <= cmd_word; end
          S_RD:     mem_addr <= 3'd0;
          S_ABORT:  begin mem_addr <= 3'd2; data_from_cpu <= 16'h0000; err <= 1'b1; end
          default:  ;
        endcase
      end

      if (state == S_RD && ph)
        rx <= data_to_cpu;

      if (state == S_STORE) begin
        seq <= seq + 4'd1;
        if (!discard) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (ch == 3'(k)) begin
              result[k]     <= rx;
              valid_mask[k] <= 1'b1;
            end
          end
          ch <= ch + 3'd1;
        end
      end
    end
  end

  // Result bank read port; out-of-range indices read as zero
  always_comb begin
    rd_data = 16'h0000;
    for (int k = 0; k < NUM_CH; k++)
      if (rd_ch == 3'(k)) rd_data = result[k];
  end

endmodule

// File: tb/tb_spi_adc_sequencer.sv
// Bench for spi_adc_sequencer: SPI-master register-port slave model, bus
// monitor, and a directed sequence with randomized replies and latencies.
module tb_spi_adc_sequencer;

  localparam int NCH     = 2;
  localparam int PIPE    = 1;
  localparam int TMO     = 2048;
  localparam int PER     = 100;
  localparam int N_XFER  = NCH + PIPE;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        auto_en = 1'b0;
  logic [2:0]  rd_ch = 3'd0;
  logic        busy, done, err, overrun;
  logic [15:0] rd_data;
  logic [NCH-1:0] valid_mask;
  logic        spi_select, read_n, write_n;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu = 16'h0000;
  logic        trdy = 1'b1;
  logic        rrdy = 1'b0;

  spi_adc_sequencer #(.NUM_CH(NCH), .PERIOD(PER), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .auto_en(auto_en),
    .busy(busy), .done(done), .err(err), .overrun(overrun),
    .rd_ch(rd_ch), .rd_data(rd_data), .valid_mask(valid_mask),
    .spi_select(spi_select), .mem_addr(mem_addr), .read_n(read_n),
    .write_n(write_n), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
    .readyfordata(trdy), .dataavailable(rrdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [2:0]  addr;
    logic [15:0] data;
    int          len;
    int          start;
    bit          stable;
    bit          trdy_ok;
  } acc_t;

  acc_t  acc_q[$];
  acc_t  cur;
  int    run = 0;
  int    cyc = 0;
  int    proto_err = 0;
  int    done_cnt = 0;
  int    dly = 0;
  int    dmin = 2, dmax = 6;
  bit    no_rrdy = 1'b0;
  bit    prev_valid = 1'b0;
  logic [2:0]  prev_c = 3'd0;
  logic [15:0] pend = 16'h0000;
  logic [15:0] salt = 16'hA000;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave reply for the command that addressed channel c in this scan.
  function automatic logic [15:0] reply_for(input logic [15:0] s, input logic [2:0] c);
    return {s[15:3], c};
  endfunction

  // Bus monitor and SPI-master register-port model, both on the falling edge
  always @(negedge clk) begin
    if (!reset_n) begin
      run = 0; trdy = 1'b1; rrdy = 1'b0; dly = 0; prev_valid = 1'b0;
    end else begin
      cyc++;
      if (done) done_cnt++;
      if (!read_n && !write_n) proto_err++;
      if (!read_n || !write_n) begin
        if (!spi_select) proto_err++;
        if (run == 0) begin
          cur.we      = !write_n;
          cur.addr    = mem_addr;
          cur.data    = !write_n ? data_from_cpu : 16'h0000;
          cur.start   = cyc;
          cur.stable  = 1'b1;
          cur.trdy_ok = !(!write_n && mem_addr == 3'd1 && !trdy);
        end else if (cur.we != !write_n || cur.addr != mem_addr ||
                     (cur.we && cur.data != data_from_cpu)) begin
          cur.stable = 1'b0;
        end
        run++;
      end else begin
        if (spi_select) proto_err++;
        if (run > 0) begin
          cur.len = run;
          acc_q.push_back(cur);
          run = 0;
          if (cur.we && cur.addr == 3'd1) begin
            pend = prev_valid ? reply_for(salt, prev_c) : 16'hDEAD;
            prev_c = cur.data[12:10];
            prev_valid = 1'b1;
            trdy = 1'b0; rrdy = 1'b0;
            dly = $urandom_range(dmax, dmin);
          end else if (!cur.we && cur.addr == 3'd0) begin
            rrdy = 1'b0;
          end else if (cur.we && cur.addr == 3'd2) begin
            rrdy = 1'b0; trdy = 1'b1;
          end
        end
      end
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          trdy = 1'b1;
          if (!no_rrdy) begin rrdy = 1'b1; data_to_cpu = pend; end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  function automatic int n_ss();
    int n = 0;
    foreach (acc_q[i]) if (acc_q[i].we && acc_q[i].addr == 3'd5) n++;
    return n;
  endfunction

  function automatic logic [15:0] exp_cmd(input int s);
    int c = (s < NCH - 1) ? s : NCH - 1;
    return 16'h8310 | 16'(c << 10);
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Checks the bus log, result bank and flags of a completed good scan.
  task automatic check_scan(input string tag);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_valid"}, valid_mask, 2'b11);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_nacc"}, acc_q.size(), 1 + 2 * N_XFER);
    if (acc_q.size() == 1 + 2 * N_XFER) begin
      chk({tag, "_ss"}, {acc_q[0].we, acc_q[0].addr, acc_q[0].data}, {1'b1, 3'd5, 16'h0001});
      for (int s = 0; s < N_XFER; s++) begin
        chk({tag, "_cmd"}, {acc_q[1+2*s].we, acc_q[1+2*s].addr, acc_q[1+2*s].data},
            {1'b1, 3'd1, exp_cmd(s)});
        chk({tag, "_rd"}, {acc_q[2+2*s].we, acc_q[2+2*s].addr}, {1'b0, 3'd0});
      end
    end
    foreach (acc_q[i]) begin
      chk({tag, "_len"}, acc_q[i].len, 2);
      chk({tag, "_stable"}, acc_q[i].stable, 1);
      chk({tag, "_trdy"}, acc_q[i].trdy_ok, 1);
    end
    chk({tag, "_proto"}, proto_err, 0);
    for (int k = 0; k < NCH; k++) begin
      rd_ch = 3'(k); #1;
      chk({tag, "_res"}, rd_data, reply_for(salt, 3'(k)));
    end
    rd_ch = 3'd6; #1;
    chk({tag, "_res_oor"}, rd_data, 16'h0000);
  endtask

  task automatic good_scan(input string tag, input logic [15:0] s);
    int d0;
    bit ok;
    acc_q.delete();
    d0 = done_cnt;
    salt = s;
    pulse_start();
    wait_done(600, ok);
    chk({tag, "_done_seen"}, ok, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    check_scan(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    acc_t a;
    int   d0;
    bit   ok;

    // reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_valid", valid_mask, 0);
    chk("rst_sel", spi_select, 0);
    chk("rst_strobes", {read_n, write_n}, 2'b11);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", data_from_cpu, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed scan with the documented echo pattern
    good_scan("dir", 16'hA000);

    // randomized replies and slave latencies
    for (int i = 0; i < 4; i++) begin
      dmin = $urandom_range(6, 2);
      dmax = dmin + $urandom_range(8, 0);
      good_scan("rnd", 16'($urandom()));
    end

    // RRDY never arrives: timeout abort
    no_rrdy = 1'b1; dmin = 3; dmax = 3;
    acc_q.delete();
    d0 = done_cnt;
    pulse_start();
    wait_done(3000, ok);
    chk("tmo_done_seen", ok, 1);
    repeat (3) @(negedge clk);
    chk("tmo_done_pulses", done_cnt - d0, 1);
    chk("tmo_err", err, 1);
    chk("tmo_valid", valid_mask, 0);
    chk("tmo_nacc", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      a = acc_q[2];
      chk("tmo_clr", {a.we, a.addr, a.len}, {1'b1, 3'd2, 32'd2});
      chk("tmo_cmd", acc_q[1].data, 16'h8310);
      chk("tmo_latency", a.start - acc_q[1].start, TMO + 3);
    end
    chk("tmo_proto", proto_err, 0);
    no_rrdy = 1'b0;

    // long scans under auto trigger: second tick overruns
    dmin = 40; dmax = 40;
    salt = 16'h8000 | 16'($urandom());
    acc_q.delete();
    d0 = done_cnt;
    @(negedge clk) auto_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) begin ok = 1'b1; break; end
    end
    chk("ovr_scan_started", ok, 1);
    chk("ovr_err_cleared", err, 0);
    chk("ovr_not_yet", overrun, 0);
    wait_done(400, ok);
    chk("ovr_done_seen", ok, 1);
    @(negedge clk);
    chk("ovr_flag", overrun, 1);
    chk("ovr_one_scan", n_ss(), 1);
    chk("ovr_done_pulses", done_cnt - d0, 1);
    auto_en = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", overrun, 0);
    repeat (150) @(negedge clk);
    chk("ovr_no_rescan", n_ss(), 1);

    // asynchronous reset while waiting for RRDY
    dmin = 30; dmax = 30;
    acc_q.delete();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_q.size() >= 2) begin ok = 1'b1; break; end
    end
    chk("rst_mid_cmd_seen", ok, 1);
    repeat (5) @(negedge clk);
    rd_ch = 3'd0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_sel", spi_select, 0);
    chk("arst_strobes", {read_n, write_n}, 2'b11);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wdata", data_from_cpu, 0);
    chk("arst_valid", valid_mask, 0);
    chk("arst_flags", {done, err, overrun}, 3'b000);
    chk("arst_result", rd_data, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    proto_err = 0;
    dmin = 2; dmax = 6;
    repeat (2) @(negedge clk);
    good_scan("post_rst", 16'($urandom()));

    // start coincident with the period tick: one scan, no overrun
    acc_q.delete();
    d0 = done_cnt;
    salt = 16'($urandom());
    @(negedge clk) auto_en = 1'b1;
    repeat (PER - 1) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(200, ok);
    chk("coin_done_seen", ok, 1);
    repeat (3) @(negedge clk);
    chk("coin_overrun", overrun, 0);
    chk("coin_one_scan", n_ss(), 1);
    chk("coin_done_pulses", done_cnt - d0, 1);
    chk("coin_valid", valid_mask, 2'b11);
    auto_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
